// File: rtl/approx_mul8_seq.sv
// Sequential 8x8 unsigned approximate multiplier: one 4x4 core time-shared over four nibble
// partial products. Define APPROX_MUL8_SEQ_EXACT_EN to make the core exact (golden reference).
module approx_mul8_seq #(
  parameter int unsigned PP_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_y,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] pp_q, pp_d;

  logic [3:0]  core_x, core_y;
  logic [7:0]  core_p;
  logic [15:0] pp_cur;

`ifdef APPROX_MUL8_SEQ_EXACT_EN
  function automatic logic [7:0] p4(input logic [3:0] x, input logic [3:0] y);
    return {4'b0, x} * {4'b0, y};
  endfunction
`else
  // 2x2 digit product with the single approximation 3*3 -> 7
  function automatic logic [3:0] k2(input logic [1:0] u, input logic [1:0] v);
    if (u == 2'd3 && v == 2'd3) return 4'd7;
    return {2'b0, u} * {2'b0, v};
  endfunction

  function automatic logic [7:0] p4(input logic [3:0] x, input logic [3:0] y);
    return {4'b0, k2(x[1:0], y[1:0])}
         + {2'b0, k2(x[3:2], y[1:0]), 2'b0}
         + {2'b0, k2(x[1:0], y[3:2]), 2'b0}
         + {k2(x[3:2], y[3:2]), 4'b0};
  endfunction
`endif

  // Step order: aL*bL, aH*bL, aL*bH, aH*bH
  always_comb begin
    core_x = step_q[0] ? a_q[7:4] : a_q[3:0];
    core_y = step_q[1] ? b_q[7:4] : b_q[3:0];
    core_p = p4(core_x, core_y);
    unique case (step_q)
      2'd0:    pp_cur = {8'b0, core_p};
      2'd3:    pp_cur = {core_p, 8'b0};
      default: pp_cur = {4'b0, core_p, 4'b0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    pp_d    = pp_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          pp_d    = '0;
          step_d  = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // With PP_REG the accumulator trails the core by one step; pp_q is zero at step 0
        if (PP_REG != 0) begin
          pp_d  = pp_cur;
          acc_d = acc_q + pp_q;
        end else begin
          acc_d = acc_q + pp_cur;
        end
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = (PP_REG != 0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        acc_d   = acc_q + pp_q;
        pp_d    = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      pp_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      pp_q    <= pp_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE) && !rst;
  assign busy      = (state_q != S_IDLE) && !rst;
  assign out_y     = rst ? '0 : acc_q;

endmodule
